mem_access_stage: RTL

- Pipeline MEM stage; sits directly downstream of the execute stage and consumes its result, RAM address, store data, load/store type and misaligned flag.
- Issues data-memory accesses over a req/gnt/rvalid handshake, steers and sign-extends load bytes, and builds store strobes.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the writeback bundle for WB; raises misaligned and access-timeout traps.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_access_stage_align.sv | 52 +++++
 rtl/mem_access_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 codes, trap causes, FSM states.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// Byte-lane steering: load extraction/extension and store strobe/replication.
module mem_access_stage_align
    import mem_pkg::*;
(
    input  logic [1:0]  ld_lane,
    input  logic [2:0]  load_type,
    input  logic [31:0] rdata,
    input  logic [1:0]  st_lane,
    input  logic [2:0]  store_type,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata[{ld_lane, 3'b000} +: 8];
    assign ld_half = rdata[{ld_lane[1], 4'b0000} +: 16];

    always_comb begin
        load_value = rdata;
        case (load_type)
            F3_LB:   load_value = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  load_value = {24'b0, ld_byte};
            F3_LH:   load_value = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  load_value = {16'b0, ld_half};
            default: load_value = rdata;
        endcase
    end

    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (store_type)
            F3_SB: begin
                wstrb = 4'b0001 << st_lane;
                wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                wstrb = 4'b0011 << {st_lane[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: data-memory access FSM, writeback bundle and trap generation.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_ram_address,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic        misaligned,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_wb_valid,
    output logic [4:0]  mem_wb_rd,
    output logic [31:0] mem_wb_result,
    output logic        mem_wb_reg_write,
    output logic        mem_trap,
    output logic [3:0]  mem_trap_cause,
    output logic [31:0] mem_trap_addr
);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [4:0]       rd_q;
    logic             rw_q;
    logic             load_q;
    logic             we_q;
    logic [2:0]       ltype_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      wdata_q;

    logic             is_mem;
    logic             start;
    logic             timeout;
    logic [31:0]      load_value;
    logic [3:0]       st_strb;
    logic [31:0]      st_data;

    assign is_mem  = is_load | is_store;
    assign start   = ex_valid & is_mem & ~misaligned;
    assign timeout = (state != S_IDLE) &&
                     (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    mem_access_stage_align u_align (
        .ld_lane    (addr_q[1:0]),
        .load_type  (ltype_q),
        .rdata      (dmem_rdata),
        .st_lane    (ex_ram_address[1:0]),
        .store_type (store_type),
        .store_data (ex_store_data),
        .load_value (load_value),
        .wstrb      (st_strb),
        .wdata      (st_data)
    );

    assign dmem_req   = (state == S_REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q[31:2];
    assign dmem_wstrb = wstrb_q;
    assign dmem_wdata = wdata_q;

    // Stall also drops on timeout so the faulting instruction is not reissued.
    assign mem_stall = ((state == S_IDLE) & start) |
                       ((state == S_REQ) & ~timeout) |
                       ((state == S_RESP) & ~dmem_rvalid & ~timeout);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            addr_q           <= '0;
            rd_q             <= '0;
            rw_q             <= 1'b0;
            load_q           <= 1'b0;
            we_q             <= 1'b0;
            ltype_q          <= '0;
            wstrb_q          <= '0;
            wdata_q          <= '0;
            mem_wb_valid     <= 1'b0;
            mem_wb_rd        <= '0;
            mem_wb_result    <= '0;
            mem_wb_reg_write <= 1'b0;
            mem_trap         <= 1'b0;
            mem_trap_cause   <= '0;
            mem_trap_addr    <= '0;
        end else begin
            mem_wb_valid <= 1'b0;
            mem_trap     <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (ex_valid && is_mem && misaligned) begin
                        mem_wb_valid     <= 1'b1;
                        mem_wb_rd        <= ex_rd;
                        mem_wb_result    <= '0;
                        mem_wb_reg_write <= 1'b0;
                        mem_trap         <= 1'b1;
                        mem_trap_cause   <= is_load ? CAUSE_LD_MISALIGN
                                                    : CAUSE_ST_MISALIGN;
                        mem_trap_addr    <= ex_ram_address;
                    end else if (start) begin
                        state   <= S_REQ;
                        addr_q  <= ex_ram_address;
                        rd_q    <= ex_rd;
                        rw_q    <= ex_reg_write;
                        load_q  <= is_load;
                        we_q    <= ~is_load;
                        ltype_q <= load_type;
                        wstrb_q <= is_load ? 4'b0000 : st_strb;
                        wdata_q <= st_data;
                    end else if (ex_valid) begin
                        mem_wb_valid     <= 1'b1;
                        mem_wb_rd        <= ex_rd;
                        mem_wb_result    <= ex_result;
                        mem_wb_reg_write <= ex_reg_write;
                    end
                end
                S_REQ, S_RESP: begin
                    cnt <= cnt + 1'b1;
                    if (state == S_RESP && dmem_rvalid) begin
                        state            <= S_IDLE;
                        mem_wb_valid     <= 1'b1;
                        mem_wb_rd        <= rd_q;
                        mem_wb_result    <= load_q ? load_value : '0;
                        mem_wb_reg_write <= load_q & rw_q;
                    end else if (timeout) begin
                        state            <= S_IDLE;
                        mem_wb_valid     <= 1'b1;
                        mem_wb_rd        <= rd_q;
                        mem_wb_result    <= '0;
                        mem_wb_reg_write <= 1'b0;
                        mem_trap         <= 1'b1;
                        mem_trap_cause   <= load_q ? CAUSE_LD_FAULT
                                                   : CAUSE_ST_FAULT;
                        mem_trap_addr    <= addr_q;
                    end else if (state == S_REQ && dmem_gnt) begin
                        state <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
